// File: rtl/debounce_pkg.sv
// Shared timing constants and width helpers for the push-button debouncers.
// Default constants assume a 100 MHz system clock.
package debounce_pkg;

    localparam int DB_STABLE_10MS         = 1_000_000;
    localparam int DB_REPEAT_DELAY_500MS  = 50_000_000;
    localparam int DB_REPEAT_PERIOD_100MS = 10_000_000;

    // Width needed to count up to max(a,b)-1, never less than one bit.
    function automatic int clog2_max(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, stability counter, event pulses
// and optional auto-repeat. press_next is the unregistered press term for OR-ing.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DB_STABLE_10MS,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = DB_REPEAT_DELAY_500MS,
    parameter int REPEAT_PERIOD = DB_REPEAT_PERIOD_100MS
) (
    input  logic clk,
    input  logic reset,
    input  logic in_raw,
    output logic level,
    output logic press,
    output logic release_ev,
    output logic repeat_ev,
    output logic press_next
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             settle;
    logic             release_next;

    // Level flips only when the counter has seen a full run of differing samples.
    assign settle       = (s2 != level) && (cnt == CNT_LAST);
    assign press_next   = settle & s2;
    assign release_next = settle & ~s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            cnt        <= '0;
            level      <= 1'b0;
            press      <= 1'b0;
            release_ev <= 1'b0;
        end else begin
            s1         <= in_raw;
            s2         <= s1;
            press      <= press_next;
            release_ev <= release_next;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    generate
        if (REPEAT_EN != 0) begin : g_repeat
            localparam int RC_W = clog2_max(REPEAT_DELAY, REPEAT_PERIOD);
            localparam logic [RC_W-1:0] DLY_LAST = RC_W'(REPEAT_DELAY - 1);
            localparam logic [RC_W-1:0] PER_LAST = RC_W'(REPEAT_PERIOD - 1);

            logic [RC_W-1:0] rc;
            logic            first;

            // The releasing edge is excluded so repeat can never share a cycle with release.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rc        <= '0;
                    first     <= 1'b0;
                    repeat_ev <= 1'b0;
                end else begin
                    repeat_ev <= 1'b0;
                    if (press_next) begin
                        rc    <= '0;
                        first <= 1'b1;
                    end else if (level && !release_next) begin
                        if (first && (rc == DLY_LAST)) begin
                            repeat_ev <= 1'b1;
                            rc        <= '0;
                            first     <= 1'b0;
                        end else if (!first && (rc == PER_LAST)) begin
                            repeat_ev <= 1'b1;
                            rc        <= '0;
                        end else begin
                            rc <= rc + 1'b1;
                        end
                    end else begin
                        rc <= '0;
                    end
                end
            end
        end else begin : g_no_repeat
            assign repeat_ev = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/button_debounce_array.sv
// Multi-channel push-button debouncer with press/release events and auto-repeat.
// release/repeat are reserved words, so those outputs carry an _ev suffix.
module button_debounce_array
    import debounce_pkg::*;
#(
    parameter int NUM_CH        = 5,
    parameter int STABLE_CYCLES = DB_STABLE_10MS,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = DB_REPEAT_DELAY_500MS,
    parameter int REPEAT_PERIOD = DB_REPEAT_PERIOD_100MS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] in_raw,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] press,
    output logic [NUM_CH-1:0] release_ev,
    output logic [NUM_CH-1:0] repeat_ev,
    output logic              any_press
);

    logic [NUM_CH-1:0] press_next;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            debounce_channel #(
                .STABLE_CYCLES (STABLE_CYCLES),
                .REPEAT_EN     (REPEAT_EN),
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD)
            ) u_ch (
                .clk        (clk),
                .reset      (reset),
                .in_raw     (in_raw[i]),
                .level      (level[i]),
                .press      (press[i]),
                .release_ev (release_ev[i]),
                .repeat_ev  (repeat_ev[i]),
                .press_next (press_next[i])
            );
        end
    endgenerate

    // Registered from the same terms as press, so it lines up with press exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_next;
        end
    end

endmodule

// File: tb/tb_button_debounce_array.sv
// Randomised and directed bench for button_debounce_array against a
// sample-window reference model.
module tb_button_debounce_array;

    localparam int NCH = 2;
    localparam int S   = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam int HMAX = 8192;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] in_raw;
    logic [NCH-1:0] level, press, release_ev, repeat_ev;
    logic           any_press;

    button_debounce_array #(
        .NUM_CH        (NCH),
        .STABLE_CYCLES (S),
        .REPEAT_EN     (1),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_raw     (in_raw),
        .level      (level),
        .press      (press),
        .release_ev (release_ev),
        .repeat_ev  (repeat_ev),
        .any_press  (any_press)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: hist holds the value sampled at each edge, -1 where reset
    // invalidated it. A level flips at edge n when samples n-1-S..n-2 are all
    // valid and all differ from the current level.
    int             hist [NCH][HMAX];
    int             pedge[NCH];
    int             n = 0;
    logic [NCH-1:0] m_level = '0, m_press = '0, m_rel = '0, m_rep = '0;
    logic           m_any = 1'b0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n - 1);
        end
    endtask

    task automatic model_edge(input logic r, input logic [NCH-1:0] v);
        logic flip;
        int   d;
        for (int c = 0; c < NCH; c++) begin
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            m_rep[c]   = 1'b0;
            if (r) begin
                m_level[c] = 1'b0;
                hist[c][n] = -1;
                if (n > 0) hist[c][n-1] = -1;
            end else begin
                hist[c][n] = int'(v[c]);
                flip = (n - 1 - S >= 0);
                for (int m = n - 1 - S; m <= n - 2; m++) begin
                    if (m < 0) flip = 1'b0;
                    else if (hist[c][m] < 0 || hist[c][m] == int'(m_level[c])) flip = 1'b0;
                end
                if (m_level[c] && !flip) begin
                    d = n - pedge[c];
                    m_rep[c] = (d == RD) || (d > RD && ((d - RD) % RP) == 0);
                end
                if (flip) begin
                    m_level[c] = ~m_level[c];
                    m_press[c] = m_level[c];
                    m_rel[c]   = ~m_level[c];
                    if (m_level[c]) pedge[c] = n;
                end
            end
        end
        m_any = |m_press;
        n++;
    endtask

    task automatic tick(input logic r, input logic [NCH-1:0] v);
        reset  = r;
        in_raw = v;
        @(posedge clk);
        model_edge(r, v);
        #1;
        check_eq("level",     int'(level),      int'(m_level));
        check_eq("press",     int'(press),      int'(m_press));
        check_eq("release",   int'(release_ev), int'(m_rel));
        check_eq("repeat",    int'(repeat_ev),  int'(m_rep));
        check_eq("any_press", int'(any_press),  int'(m_any));
    endtask

    task automatic run(input logic r, input logic [NCH-1:0] v, input int cycles);
        for (int i = 0; i < cycles; i++) tick(r, v);
    endtask

    int             t_press;
    int             n_press;
    logic [NCH-1:0] cur;
    int             hold[NCH];

    initial begin
        for (int c = 0; c < NCH; c++) begin
            pedge[c] = 0;
            for (int i = 0; i < HMAX; i++) hist[c][i] = -1;
        end
        reset  = 1'b1;
        in_raw = '0;

        // Button held through reset: press expected on the 6th edge after release.
        run(1'b1, 2'b01, 3);
        t_press = -1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 2'b01);
            if (press[0] && t_press < 0) t_press = i;
        end
        check_eq("hold_press_edge", t_press, S + 1);
        run(1'b0, 2'b00, 12);

        // Bounce, then settle high and hold for auto-repeat, then drop.
        for (int i = 0; i < 20; i++) tick(1'b0, {1'b0, 1'(i / 2 % 2 == 0)});
        n_press = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 2'b01);
            if (press[0]) n_press++;
        end
        check_eq("bounce_one_press", n_press, 1);
        run(1'b0, 2'b00, 12);

        // Glitch rejection on channel 1: 3-cycle and 4-cycle pulses.
        run(1'b0, 2'b10, 3);
        run(1'b0, 2'b00, 10);
        run(1'b0, 2'b10, 4);
        run(1'b0, 2'b00, 12);

        // Simultaneous press on both channels.
        run(1'b0, 2'b11, 10);
        run(1'b0, 2'b00, 10);

        // Reset mid-count, then reset while level is high.
        run(1'b0, 2'b01, 4);
        tick(1'b1, 2'b01);
        t_press = -1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 2'b01);
            if (press[0] && t_press < 0) t_press = i;
        end
        check_eq("reset_refire_edge", t_press, S + 1);
        tick(1'b1, 2'b01);
        check_eq("reset_clears_level", int'(level), 0);
        run(1'b0, 2'b01, 10);
        run(1'b0, 2'b00, 10);

        // Random bouncing with long holds and occasional resets.
        cur = '0;
        for (int c = 0; c < NCH; c++) hold[c] = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if (hold[c] == 0) begin
                    cur[c]  = ~cur[c];
                    hold[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                                          : int'($urandom_range(5, 25));
                end
                hold[c]--;
            end
            tick($urandom_range(0, 99) == 0, cur);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
